// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler that shares one interval counter between N_REQ requesters.
// Optional feature: define TIMER_SCHED_CANCEL_EN to add the per-requester CANCEL abort port.
module timer_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 21
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ*CNT_W-1:0]   REQ_LEN,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [N_REQ-1:0]         CANCEL,
`endif
    output logic [N_REQ-1:0]         ACK,
    output logic [N_REQ-1:0]         DONE,
    output logic                     BUSY,
    output logic [$clog2(N_REQ)-1:0] GRANT_ID
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic {
        StIdle,
        StCount
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic             any_req;
    logic [ID_W-1:0]  win_id;
    logic             cancel_hit;
    logic [CNT_W-1:0] req_len_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_len
        assign req_len_arr[i] = REQ_LEN[i*CNT_W +: CNT_W];
    end

`ifdef TIMER_SCHED_CANCEL_EN
    assign cancel_hit = CANCEL[grant_id_q];
`else
    assign cancel_hit = 1'b0;
`endif

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
        int unsigned sum;
        sum = (32'(base) + off) % N_REQ;
        return ID_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            if (REQ[rr_idx(last_grant_q, k)]) begin
                any_req = 1'b1;
                win_id  = rr_idx(last_grant_q, k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        ack_d        = '0;
        done_d       = '0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d        = StCount;
                    grant_id_d     = win_id;
                    last_grant_d   = win_id;
                    len_d          = req_len_arr[win_id];
                    cnt_d          = '0;
                    ack_d[win_id]  = 1'b1;
                end
            end
            StCount: begin
                // Cancel wins over completion on the same edge.
                if (cancel_hit) begin
                    state_d = StIdle;
                end else if (cnt_q == len_q) begin
                    state_d              = StIdle;
                    done_d[grant_id_q]   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            len_q        <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            grant_id_q   <= '0;
            ack_q        <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
        end
    end

    assign ACK      = ack_q;
    assign DONE     = done_q;
    assign BUSY     = (state_q == StCount);
    assign GRANT_ID = grant_id_q;

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: table vectors, hand-written corner sequences and a randomized run against a
// deadline-based reference model of timer_sched.
module tb_timer_sched;

    localparam int N_REQ = 4;
    localparam int CNT_W = 21;
    localparam int ID_W  = $clog2(N_REQ);

    logic                   CLK     = 1'b0;
    logic                   RST_N   = 1'b1;
    logic [N_REQ-1:0]       REQ     = '0;
    logic [N_REQ*CNT_W-1:0] REQ_LEN = '0;
    logic [N_REQ-1:0]       ACK;
    logic [N_REQ-1:0]       DONE;
    logic                   BUSY;
    logic [ID_W-1:0]        GRANT_ID;
`ifdef TIMER_SCHED_CANCEL_EN
    logic [N_REQ-1:0]       CANCEL  = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    timer_sched #(
        .N_REQ(N_REQ),
        .CNT_W(CNT_W)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .REQ_LEN (REQ_LEN),
`ifdef TIMER_SCHED_CANCEL_EN
        .CANCEL  (CANCEL),
`endif
        .ACK     (ACK),
        .DONE    (DONE),
        .BUSY    (BUSY),
        .GRANT_ID(GRANT_ID)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lane(input int i, input int len);
        REQ_LEN[i*CNT_W +: CNT_W] = CNT_W'(len);
    endtask

    function automatic int oh_id(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        REQ = '0;
`ifdef TIMER_SCHED_CANCEL_EN
        CANCEL = '0;
`endif
        RST_N = 1'b0;
        #1;
        step();
        step();
        RST_N = 1'b1;
    endtask

    // Reference model: tracks the owner and the absolute cycle its DONE is due.
    bit               m_busy;
    int               m_owner, m_last, m_gid;
    longint           m_t, m_done_at;
    logic [N_REQ-1:0] e_ack, e_done;

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_last = N_REQ - 1; m_gid = 0;
        m_t = 0; m_done_at = 0; e_ack = '0; e_done = '0;
    endfunction

    function automatic void model_edge();
        int w;
        m_t++;
        e_ack  = '0;
        e_done = '0;
        if (m_busy) begin
            if (m_t == m_done_at) begin
                e_done[m_owner] = 1'b1;
                m_busy = 0;
            end
        end else if (REQ != 0) begin
            w = -1;
            for (int k = 1; k <= N_REQ; k++) begin
                if (w < 0 && REQ[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
            end
            e_ack[w]  = 1'b1;
            m_busy    = 1;
            m_owner   = w;
            m_last    = w;
            m_gid     = w;
            m_done_at = m_t + longint'(REQ_LEN[w*CNT_W +: CNT_W]) + 1;
        end
    endfunction

    typedef struct {
        logic [N_REQ-1:0] req;
        int               len;
        int               id;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n, na, nd, id;
        int gid[4], gt[4], dt[4];
        logic [N_REQ-1:0] acc;
        bit pulsed;

        // Sequential table: expected winners follow from the rotating last_grant.
        vecs[0] = '{4'b0001, 5, 0};
        vecs[1] = '{4'b0001, 0, 0};
        vecs[2] = '{4'b1010, 3, 1};
        vecs[3] = '{4'b1010, 2, 3};
        vecs[4] = '{4'b0110, 1, 1};
        vecs[5] = '{4'b1111, 4, 2};
        vecs[6] = '{4'b1001, 0, 3};
        vecs[7] = '{4'b0100, 7, 2};

        #2;
        do_reset();
        check("rst_ack", 64'(ACK), 0);
        check("rst_done", 64'(DONE), 0);
        check("rst_busy", 64'(BUSY), 0);
        check("rst_gid", 64'(GRANT_ID), 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N_REQ; i++)
                set_lane(i, (i == vecs[v].id) ? vecs[v].len : vecs[v].len + 10 + i);
            REQ = vecs[v].req;
            step();
            check("vec_ack", 64'(ACK), 64'(1 << vecs[v].id));
            check("vec_gid", 64'(GRANT_ID), 64'(vecs[v].id));
            check("vec_busy", 64'(BUSY), 1);
            REQ = '0;
            n = 0;
            while (n < 64) begin
                step();
                n++;
                if (DONE != 0) break;
                check("vec_busy_run", 64'(BUSY), 1);
            end
            check("vec_latency", 64'(n), 64'(vecs[v].len + 1));
            check("vec_done", 64'(DONE), 64'(1 << vecs[v].id));
            check("vec_busy_end", 64'(BUSY), 0);
            check("vec_ack_end", 64'(ACK), 0);
            step();
            check("vec_done_pulse", 64'(DONE), 0);
        end

        // All four requesting, len 2: grants 0..3, DONE every 4 cycles.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_lane(i, 2);
        REQ = 4'b1111;
        na = 0; nd = 0;
        for (int cyc = 1; cyc <= 60 && nd < 4; cyc++) begin
            step();
            if (ACK != 0 && na < 4) begin
                gid[na] = oh_id(ACK); gt[na] = cyc; na++;
                REQ = REQ & ~ACK;
            end
            if (DONE != 0 && nd < 4) begin
                dt[nd] = cyc; nd++;
            end
        end
        check("all_nack", 64'(na), 4);
        check("all_ndone", 64'(nd), 4);
        if (na == 4 && nd == 4) begin
            for (int k = 0; k < 4; k++) begin
                check("all_order", 64'(gid[k]), 64'(k));
                check("all_lat", 64'(dt[k] - gt[k]), 3);
                if (k > 0) check("all_spacing", 64'(dt[k] - dt[k-1]), 4);
            end
        end

        // REQ[2] held, REQ[1] pulsed once: 2, 1, 2, 2.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_lane(i, 1);
        REQ = 4'b0100;
        n = 0; pulsed = 0;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            step();
            if (ACK != 0) begin
                id = oh_id(ACK);
                gid[n] = id; n++;
                if (id == 2 && !pulsed) begin REQ[1] = 1'b1; pulsed = 1; end
                if (id == 1) REQ[1] = 1'b0;
            end
        end
        check("rr_count", 64'(n), 4);
        if (n == 4) begin
            check("rr_0", 64'(gid[0]), 2);
            check("rr_1", 64'(gid[1]), 1);
            check("rr_2", 64'(gid[2]), 2);
            check("rr_3", 64'(gid[3]), 2);
        end
        REQ = '0;
        for (int cyc = 0; cyc < 10 && BUSY; cyc++) step();
        check("rr_idle", 64'(BUSY), 0);

        // Requester 3 withdraws while requester 0 runs: never acknowledged.
        set_lane(0, 8);
        set_lane(3, 4);
        REQ = 4'b0001;
        step();
        check("wd_ack0", 64'(ACK), 1);
        REQ = 4'b1000;
        acc = '0;
        for (int c = 0; c < 3; c++) begin step(); acc = acc | ACK; end
        REQ = '0;
        for (int c = 0; c < 20; c++) begin step(); acc = acc | ACK | DONE; end
        check("wd_no_ack3", 64'(acc & 4'b1000), 0);
        check("wd_done0", 64'(acc & 4'b0001), 1);

        // Reset at cnt=3 of len=10.
        set_lane(2, 10);
        REQ = 4'b0100;
        step();
        check("mr_ack", 64'(ACK), 64'(4'b0100));
        REQ = '0;
        repeat (3) step();
        RST_N = 1'b0;
        #1;
        check("mr_ack0", 64'(ACK), 0);
        check("mr_done0", 64'(DONE), 0);
        check("mr_busy0", 64'(BUSY), 0);
        check("mr_gid0", 64'(GRANT_ID), 0);
        step();
        step();
        RST_N = 1'b1;
        acc = '0;
        for (int c = 0; c < 15; c++) begin step(); acc = acc | DONE; end
        check("mr_no_done", 64'(acc), 0);
        for (int i = 0; i < N_REQ; i++) set_lane(i, 0);
        REQ = 4'b1111;
        step();
        check("mr_first_req0", 64'(ACK), 1);
        REQ = '0;
        repeat (3) step();

`ifdef TIMER_SCHED_CANCEL_EN
        // Non-owner cancel ignored; owner cancel at cnt=4 of len=9 drops BUSY, no DONE.
        do_reset();
        set_lane(0, 9);
        set_lane(1, 30);
        REQ = 4'b0001;
        step();
        check("cx_ack0", 64'(ACK), 1);
        REQ = 4'b0010;
        repeat (3) step();
        CANCEL = 4'b0010;
        step();
        check("cx_nonowner_busy", 64'(BUSY), 1);
        CANCEL = 4'b0001;
        step();
        check("cx_busy_low", 64'(BUSY), 0);
        check("cx_no_done", 64'(DONE), 0);
        CANCEL = '0;
        step();
        check("cx_next_grant", 64'(ACK), 64'(4'b0010));
        REQ = '0;
        acc = '0;
        for (int c = 0; c < 12; c++) begin step(); acc = acc | DONE; end
        check("cx_no_done0", 64'(acc & 4'b0001), 0);
        for (int c = 0; c < 50 && BUSY; c++) step();
        check("cx_idle", 64'(BUSY), 0);
`endif

        // Randomized protocol-following requesters against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            model_edge();
            check("rnd_ack", 64'(ACK), 64'(e_ack));
            check("rnd_done", 64'(DONE), 64'(e_done));
            check("rnd_busy", 64'(BUSY), 64'(m_busy));
            check("rnd_gid", 64'(GRANT_ID), 64'(m_gid));
            for (int i = 0; i < N_REQ; i++) begin
                if (REQ[i] && ACK[i]) begin
                    REQ[i] = ($urandom_range(0, 3) == 0);
                end else if (REQ[i]) begin
                    if ($urandom_range(0, 15) == 0) REQ[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    REQ[i] = 1'b1;
                    set_lane(i, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40)
                                                           : $urandom_range(0, 5));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
